// File: rtl/dswt_pkg.sv
// Shared types and constants for the pad reader: FSM state encoding and pad geometry.
package dswt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_HI,
    CLK_LO,
    COMMIT
  } pad_state_t;

  localparam int PAD_BITS = 8;
  localparam int MAX_PADS = 6;

endpackage

// File: rtl/pad_shift.sv
// Sampling register shared by all pads: each sample lands at its button bit position.
// q_next presents the byte including the bit being sampled this cycle, so the caller
// can capture a completed byte on the same edge as the final sample.
module pad_shift
  import dswt_pkg::*;
(
  input  logic                PCLK,
  input  logic                PRESERN,
  input  logic                clr,
  input  logic                load,
  input  logic [2:0]          idx,
  input  logic                din,
  output logic [PAD_BITS-1:0] q_next
);

  logic [PAD_BITS-1:0] q;

  // Merge the incoming sample into its bit position when load is strobed.
  always_comb begin
    q_next = q;
    if (load) begin
      q_next[idx] = din;
    end
  end

  // Hold the partially assembled byte; cleared at frame start.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/pad_reader.sv
// Polls up to six NES-style serial pads over a shared latch/clock pair and a muxed
// data line, publishing active-high button bytes, a frame strobe and a change irq.
// Optional feature macro: PAD_READER_DEBOUNCE_EN -- a pad's byte is committed only
// when two consecutive frames read the same value (keeps one history byte per pad).
module pad_reader
  import dswt_pkg::*;
#(
  parameter int NUM_PADS    = 1,
  parameter int HALF        = 600,
  parameter int POLL_PERIOD = 1666667
) (
  input  logic                         PCLK,
  input  logic                         PRESERN,
  input  logic                         en,
  input  logic                         data,
  input  logic                         irq_clr,
  output logic                         latch,
  output logic                         clock,
  output logic [MAX_PADS-1:0]          selection,
  output logic [PAD_BITS*NUM_PADS-1:0] buttons,
  output logic                         upd,
  output logic                         irq
);

  localparam int CNT_W = $clog2(POLL_PERIOD);
  localparam int TMR_W = $clog2(2 * HALF);
  localparam int PAD_W = $clog2(MAX_PADS);

  localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_PERIOD - 1);
  localparam logic [TMR_W-1:0] LATCH_LAST = TMR_W'(2 * HALF - 1);
  localparam logic [TMR_W-1:0] HALF_LAST  = TMR_W'(HALF - 1);
  localparam logic [PAD_W-1:0] LAST_PAD   = PAD_W'(NUM_PADS - 1);

  pad_state_t                  state;
  logic [TMR_W-1:0]            tmr;
  logic [PAD_W-1:0]            pad;
  logic [2:0]                  bit_idx;
  logic [CNT_W-1:0]            poll_cnt;
  logic [PAD_BITS-1:0]         raw [NUM_PADS];
  logic [PAD_BITS*NUM_PADS-1:0] btn_next;
  logic                        frame_go;
  logic                        sample;
  logic                        last_bit;
  logic [2:0]                  sh_idx;
  logic [PAD_BITS-1:0]         sh_next;
  logic                        changed;

`ifdef PAD_READER_DEBOUNCE_EN
  logic [PAD_BITS-1:0]         hist [NUM_PADS];
`endif

  assign frame_go = (state == IDLE) && (poll_cnt == '0) && en;
  assign sample   = ((state == LATCH) && (tmr == LATCH_LAST)) ||
                    ((state == CLK_LO) && (tmr == HALF_LAST));
  assign last_bit = (state == CLK_LO) && (tmr == HALF_LAST) && (bit_idx == 3'd7);
  // Bit 0 (A) is presented by the pad as soon as it is latched; later bits follow clock pulses.
  assign sh_idx   = (state == CLK_LO) ? bit_idx : 3'd0;

  pad_shift u_shift (
    .PCLK    (PCLK),
    .PRESERN (PRESERN),
    .clr     (frame_go),
    .load    (sample),
    .idx     (sh_idx),
    .din     (~data),
    .q_next  (sh_next)
  );

  // Free-running poll counter; frames may only start when it reads zero.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + 1'b1;
    end
  end

  // Frame sequencer: latch, seven clock pulses per pad, then a one-cycle commit.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state     <= IDLE;
      tmr       <= '0;
      pad       <= '0;
      bit_idx   <= '0;
      latch     <= 1'b0;
      clock     <= 1'b0;
      selection <= '0;
      upd       <= 1'b0;
    end else begin
      upd <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_go) begin
            state     <= LATCH;
            tmr       <= '0;
            pad       <= '0;
            latch     <= 1'b1;
            selection <= MAX_PADS'(1);
          end
        end
        LATCH: begin
          if (tmr == LATCH_LAST) begin
            state   <= CLK_HI;
            tmr     <= '0;
            latch   <= 1'b0;
            clock   <= 1'b1;
            bit_idx <= 3'd1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        CLK_HI: begin
          if (tmr == HALF_LAST) begin
            state <= CLK_LO;
            tmr   <= '0;
            clock <= 1'b0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        CLK_LO: begin
          if (tmr == HALF_LAST) begin
            tmr <= '0;
            if (bit_idx == 3'd7) begin
              if (pad == LAST_PAD) begin
                state     <= COMMIT;
                selection <= '0;
                upd       <= 1'b1;
              end else begin
                state     <= LATCH;
                pad       <= pad + 1'b1;
                latch     <= 1'b1;
                selection <= {selection[MAX_PADS-2:0], 1'b0};
              end
            end else begin
              state   <= CLK_HI;
              clock   <= 1'b1;
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Park each pad's completed byte until the commit cycle.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        raw[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PADS; i++) begin
        if (last_bit && (pad == PAD_W'(i))) begin
          raw[i] <= sh_next;
        end
      end
    end
  end

  // Candidate committed value: raw bytes, optionally gated by a two-frame match.
  always_comb begin
    btn_next = buttons;
    for (int i = 0; i < NUM_PADS; i++) begin
`ifdef PAD_READER_DEBOUNCE_EN
      if (raw[i] == hist[i]) begin
        btn_next[PAD_BITS*i +: PAD_BITS] = raw[i];
      end
`else
      btn_next[PAD_BITS*i +: PAD_BITS] = raw[i];
`endif
    end
  end

  assign changed = (btn_next != buttons);

`ifdef PAD_READER_DEBOUNCE_EN
  // Remember this frame's raw bytes for the next frame's match test.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        hist[i] <= '0;
      end
    end else if (state == COMMIT) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        hist[i] <= raw[i];
      end
    end
  end
`endif

  // Commit buttons and raise irq on any change; a same-cycle set beats irq_clr.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      buttons <= '0;
      irq     <= 1'b0;
    end else begin
      if (state == COMMIT) begin
        buttons <= btn_next;
      end
      if ((state == COMMIT) && changed) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pad_reader.sv
// Bench for pad_reader: two emulated NES pads behind a mux, randomized button bytes,
// and a frame-level reference model for buttons/irq (with or without debounce).
module tb_pad_reader;

  localparam int HALF = 2;
  localparam int POLL = 200;
  localparam int NP   = 2;
  localparam int F    = 16 * HALF * NP;
  localparam int PAD  = 16 * HALF;

  logic        PCLK;
  logic        PRESERN;
  logic        en;
  logic        data;
  logic        irq_clr;
  logic        latch;
  logic        clock;
  logic [5:0]  selection;
  logic [15:0] buttons;
  logic        upd;
  logic        irq;

  int checks;
  int errors;
  int since_start;
  int pidx;
  logic clk_prev;
  logic [7:0] pat [NP];
  logic [15:0] exp_btn;
  logic exp_irq;
`ifdef PAD_READER_DEBOUNCE_EN
  logic [7:0] hist [NP];
`endif

  pad_reader #(.NUM_PADS(NP), .HALF(HALF), .POLL_PERIOD(POLL)) dut (
    .PCLK      (PCLK),
    .PRESERN   (PRESERN),
    .en        (en),
    .data      (data),
    .irq_clr   (irq_clr),
    .latch     (latch),
    .clock     (clock),
    .selection (selection),
    .buttons   (buttons),
    .upd       (upd),
    .irq       (irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One fabric cycle; then the pads react to the freshly registered latch/clock/select.
  task automatic step();
    @(posedge PCLK);
    #1;
    since_start++;
    if (latch) pidx = 0;
    else if (clock && !clk_prev) pidx++;
    clk_prev = clock;
    data = 1'b1;
    for (int p = 0; p < NP; p++) begin
      if (selection[p] && pidx < 8) data = pat[p][pidx[2:0]];
    end
  endtask

  task automatic model_reset();
    exp_btn = '0;
    exp_irq = 1'b0;
`ifdef PAD_READER_DEBOUNCE_EN
    for (int p = 0; p < NP; p++) hist[p] = '0;
`endif
  endtask

  task automatic model_commit(input logic [7:0] b0, input logic [7:0] b1, input bit clr);
    logic [7:0]  r [NP];
    logic [15:0] nb;
    r[0] = b0;
    r[1] = b1;
    nb = exp_btn;
    for (int p = 0; p < NP; p++) begin
`ifdef PAD_READER_DEBOUNCE_EN
      if (r[p] == hist[p]) nb[8*p +: 8] = r[p];
      hist[p] = r[p];
`else
      nb[8*p +: 8] = r[p];
`endif
    end
    if (nb != exp_btn) exp_irq = 1'b1;
    else if (clr) exp_irq = 1'b0;
    exp_btn = nb;
  endtask

  task automatic wait_latch(input int exp_gap, input int budget);
    int n;
    int upds;
    n = 0;
    upds = 0;
    while (!latch && n < budget) begin
      step();
      n++;
      if (upd) upds++;
    end
    chk("latch_found", latch, 1);
    chk("upd_while_idle", upds, 0);
    chk("frame_gap", since_start, exp_gap);
    since_start = 0;
  endtask

  // Run one frame from its latch rise, checking every cycle against the timing rules.
  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input bit clr_commit,
                       input int en_low_at, input int rst_at, input int exp_gap);
    logic [15:0] old_btn;
    logic        old_irq;
    logic        el, ek, eu;
    logic [5:0]  es;
    int          rises;
    logic        kprev;
    int          slot, o;
    pat[0] = ~b0;
    pat[1] = ~b1;
    wait_latch(exp_gap, 2 * POLL + 10);
    old_btn = exp_btn;
    old_irq = exp_irq;
    rises = 0;
    kprev = 1'b0;
    for (int c = 0; c <= F + 1; c++) begin
      if (c > 0) step();
      irq_clr = clr_commit && (c == F);
      if (c == en_low_at) en = 1'b0;
      if (c == rst_at) begin
        PRESERN = 1'b0;
        #1;
        chk("rst_latch", latch, 0);
        chk("rst_clock", clock, 0);
        chk("rst_sel", selection, 0);
        chk("rst_buttons", buttons, 0);
        chk("rst_upd", upd, 0);
        chk("rst_irq", irq, 0);
        model_reset();
        step();
        step();
        chk("rst_hold_latch", latch, 0);
        PRESERN = 1'b1;
        since_start = 0;
        return;
      end
      if (c <= F) begin
        slot = c / PAD;
        o    = c % PAD;
        if (c < F) begin
          el = (o < 2 * HALF);
          ek = (o >= 2 * HALF) && ((((o - 2 * HALF) / HALF) % 2) == 0);
          es = 6'(1 << slot);
          eu = 1'b0;
        end else begin
          el = 1'b0;
          ek = 1'b0;
          es = '0;
          eu = 1'b1;
        end
        chk($sformatf("latch@%0d", c), latch, el);
        chk($sformatf("clock@%0d", c), clock, ek);
        chk($sformatf("sel@%0d", c), selection, es);
        chk($sformatf("upd@%0d", c), upd, eu);
        chk($sformatf("btn_hold@%0d", c), buttons, old_btn);
        chk($sformatf("irq_hold@%0d", c), irq, old_irq);
        if (clock && !kprev) rises++;
        kprev = clock;
      end else begin
        chk("clock_pulses", rises, 7 * NP);
        model_commit(b0, b1, clr_commit);
        chk("buttons_commit", buttons, exp_btn);
        chk("irq_after_commit", irq, exp_irq);
        chk("upd_drop", upd, 0);
      end
    end
  endtask

  initial begin
    logic [7:0] rb0, rb1;
    int lat_cnt;
    checks = 0;
    errors = 0;
    since_start = 0;
    pidx = 0;
    clk_prev = 1'b0;
    pat[0] = 8'hFF;
    pat[1] = 8'hFF;
    PRESERN = 1'b0;
    en = 1'b1;
    data = 1'b1;
    irq_clr = 1'b0;
    model_reset();
    #2;
    chk("init_latch", latch, 0);
    chk("init_clock", clock, 0);
    chk("init_sel", selection, 0);
    chk("init_buttons", buttons, 0);
    chk("init_upd", upd, 0);
    chk("init_irq", irq, 0);
    step();
    step();
    PRESERN = 1'b1;
    since_start = 0;

    // A pressed on pad 0, pad 1 idle; first frame right after reset release
    frame(8'h01, 8'h00, 1'b0, -1, -1, 1);
    frame(8'h01, 8'h00, 1'b1, -1, -1, POLL);
    // irq_clr coinciding with a changing commit
    frame(8'h00, 8'h80, 1'b1, -1, -1, POLL);
    frame(8'h00, 8'h80, 1'b0, -1, -1, POLL);
    // explicit clear while idle
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    exp_irq = 1'b0;
    chk("irq_clr_idle", irq, 0);
    // unchanged frame keeps irq low
    frame(8'h00, 8'h80, 1'b0, -1, -1, POLL);
    // one-frame glitch on pad 0
    frame(8'h01, 8'h80, 1'b0, -1, -1, POLL);
    frame(8'h00, 8'h80, 1'b0, -1, -1, POLL);

    for (int i = 0; i < 3; i++) begin
      rb0 = 8'($urandom);
      rb1 = 8'($urandom);
      frame(rb0, rb1, 1'($urandom_range(0, 1)), -1, -1, POLL);
      frame(rb0, rb1, 1'($urandom_range(0, 1)), -1, -1, POLL);
    end

    // en dropped mid-frame: this frame completes, the next start is skipped
    rb0 = 8'($urandom);
    rb1 = 8'($urandom);
    frame(rb0, rb1, 1'b0, 10, -1, POLL);
    lat_cnt = 0;
    while (since_start < POLL + 20) begin
      step();
      if (latch) lat_cnt++;
    end
    chk("no_latch_en_low", lat_cnt, 0);
    en = 1'b1;
    frame(rb0, rb1, 1'b0, -1, -1, 2 * POLL);

    // reset mid-frame, then immediate restart
    rb0 = 8'($urandom);
    rb1 = 8'($urandom);
    frame(rb0, rb1, 1'b0, -1, 20, POLL);
    frame(rb0, rb1, 1'b0, -1, -1, 1);
    frame(rb0, rb1, 1'b0, -1, -1, POLL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pad_reader.md
# pad_reader

Polls up to six NES-style serial game pads over one shared latch/clock pair and a single multiplexed data line. It runs in the fabric clock domain and sits directly upstream of the APB control block. It delivers active-high button bytes, a per-frame update strobe and a change interrupt; the interrupt feeds FABINT.

## Interface
- NUM_PADS, default 1: number of pads polled per frame, range 1..6.
- HALF, default 600: fabric cycles per half serial-clock period, minimum 1.
- POLL_PERIOD, default 1666667: fabric cycles between frame starts. Must exceed 16*HALF*NUM_PADS.
- PCLK  in  1  fabric clock (FAB_CLK).
- PRESERN  in  1  reset, asynchronous, active-low.
- en  in  1  polling enable. Sampled only at frame start.
- data  in  1  serial pad data, active-low buttons.
- irq_clr  in  1  one-cycle pulse that clears irq.
- latch  out  1  pad latch strobe.
- clock  out  1  pad serial clock.
- selection  out  6  one-hot pad select driving the external data mux. All zero when idle.
- buttons  out  8*NUM_PADS  committed button state, 1 = pressed. Pad p occupies bits [8p+7:8p]; bit 0 = A … bit 7 = Right.
- upd  out  1  one-cycle pulse when a frame completes.
- irq  out  1  level interrupt: some committed button changed.

## Operation
- Poll counter: free-running over 0..POLL_PERIOD-1, wraps to 0. A frame starts on the cycle the counter is 0, provided en=1 and the FSM is in IDLE.
- FSM states: IDLE, LATCH, CLK_HI, CLK_LO, COMMIT. The pad index p runs 0..NUM_PADS-1 within a frame.
- IDLE: latch=0, clock=0, selection=0.
- LATCH: selection=1<<p, latch=1, lasting 2*HALF cycles.
  - On the last LATCH cycle, ~data is shifted into raw bit 0.
  - Then go to CLK_HI.
- CLK_HI: clock=1 for HALF cycles, then go to CLK_LO.
- CLK_LO: clock=0 for HALF cycles.
  - On the last cycle, ~data is shifted into raw bit k, where k is 1..7.
  - After bit 7, advance p and go to LATCH, or go to COMMIT if p was the last pad.
- Exactly 7 clock pulses are issued per pad. selection stays constant through a pad's LATCH/CLK phases.
- COMMIT lasts one cycle:
  - upd=1.
  - Each pad's raw byte is committed to buttons according to the Configuration rule.
  - If any committed bit differs from its previous value, irq is set.
  - Then return to IDLE.
- irq set and clear:
  - irq_clr clears irq.
  - If the set and irq_clr fall on the same cycle, the set wins.
- en: deasserting en mid-frame does not abort the frame. It only suppresses later frame starts.
- Reset, including mid-frame:
  - All outputs go to 0 immediately: latch, clock, selection, buttons, upd, irq.
  - FSM goes to IDLE, poll counter to 0, raw and history registers to 0.
  - The first frame starts on the first cycle after PRESERN deasserts, if en=1.

## Timing
- Per pad: 16*HALF cycles. Frame length F = 16*HALF*NUM_PADS.
- With the frame starting at cycle 0:
  - latch rises at cycle 0.
  - Bit 0 of pad p is sampled at cycle 16*HALF*p + 2*HALF - 1.
  - upd pulses at cycle F.
  - The new buttons value is visible at cycle F+1.
- irq rises in the cycle after COMMIT.
- All outputs are registered; no combinational path runs from any input to any output.
- Counter widths: $clog2(POLL_PERIOD) for the poll counter, $clog2(2*HALF) for the phase timer.

## Configuration
- PAD_READER_DEBOUNCE_EN defined:
  - A pad's raw byte is committed only if it equals that pad's raw byte from the previous frame; otherwise buttons for that pad hold.
  - One history byte per pad is kept.
  - A change therefore needs two matching frames, so the minimum commit latency is 2 frames.
- Undefined: the raw byte is committed every frame and there is no history storage.

## Structure
- Shared package dswt_pkg holds:
  - the state enum pad_state_t (IDLE, LATCH, CLK_HI, CLK_LO, COMMIT);
  - the constant PAD_BITS = 8;
  - the constant MAX_PADS = 6.
- One sub-module, pad_shift: the 8-bit sampling shift register with load/clear, instantiated once and reused per pad. The top holds the FSM, counters, commit logic and irq.

## Test plan
Bench parameters: HALF=2, POLL_PERIOD=200, NUM_PADS=2, so F=64.

- **Single frame, fixed data.** Pad 0 drives data pattern 8'b1111_1110 (A pressed), pad 1 all 1s → upd at cycle 64; buttons=16'h0001; irq=1 at cycle 65; latch high at cycles 0–3 and 32–35; 7 clock pulses per pad.
- **Selection and timing.** Check selection=6'b000001 during cycles 0–31 and 6'b000010 during cycles 32–63, then 0 → next latch rises at cycle 200; no upd between cycles 65 and 199.
- **irq handshake.** irq_clr asserted on the cycle irq would set → irq stays 1. A later irq_clr → irq=0. An unchanged frame → irq stays 0.
- **Debounce.** With PAD_READER_DEBOUNCE_EN, pad 0 byte 0x01 for one frame then 0x00 → buttons never shows 0x01. 0x01 for two frames → commit at the second upd. Without the macro, commit happens at the first upd.
- **Reset mid-frame.** PRESERN low at cycle 20 → all outputs 0 in the same cycle. On release with en=1 → a new frame starts at the next cycle.
- **en low at cycle 10.** The current frame completes with upd at cycle 64; no latch pulse at cycle 200.
